// File: rtl/lpc_pkg.sv
// Shared LPC constants: cycle types, SYNC codes, completion status and host FSM states.
// Used by both the lpc_host initiator and the lpc bus decoder.
package lpc_pkg;

  localparam logic [1:0] CYC_IO  = 2'b00;
  localparam logic [1:0] CYC_MEM = 2'b01;

  // Bit position of DIR inside the CYCTYPE+DIR nibble (0 read, 1 write).
  localparam int DIR_BIT = 1;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SHORT = 4'b0101;
  localparam logic [3:0] SYNC_LONG  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR = 4'b1010;

  localparam logic [1:0] STAT_OK       = 2'b00;
  localparam logic [1:0] STAT_SYNC_ERR = 2'b01;
  localparam logic [1:0] STAT_ABORT    = 2'b10;
  localparam logic [1:0] STAT_UNSUP    = 2'b11;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;
  localparam logic [3:0] ST_CYCT  = 4'd2;
  localparam logic [3:0] ST_ADDR  = 4'd3;
  localparam logic [3:0] ST_WDATA = 4'd4;
  localparam logic [3:0] ST_HTAR0 = 4'd5;
  localparam logic [3:0] ST_HTAR1 = 4'd6;
  localparam logic [3:0] ST_SYNC  = 4'd7;
  localparam logic [3:0] ST_RDATA = 4'd8;
  localparam logic [3:0] ST_PTAR0 = 4'd9;
  localparam logic [3:0] ST_PTAR1 = 4'd10;
  localparam logic [3:0] ST_ABORT = 4'd11;

  function automatic logic cyc_supported(input logic [1:0] cyctype);
    return (cyctype == CYC_IO) || (cyctype == CYC_MEM);
  endfunction

endpackage

// File: rtl/lpc_nibble_shifter.sv
// Holds the address and write data of the current cycle and presents them one nibble
// per clock, most significant address nibble first, then data low nibble, then high.
module lpc_nibble_shifter (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_is_mem,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_shift,
  output logic [3:0]  o_nib_cur,
  output logic [3:0]  o_nib_nxt
);

  logic [39:0] r_shreg;

  // I/O cycles only send addr[15:0], so the data nibbles follow it directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
    end else if (i_load) begin
      if (i_is_mem)
        r_shreg <= {i_addr, i_data[3:0], i_data[7:4]};
      else
        r_shreg <= {i_addr[15:0], i_data[3:0], i_data[7:4], 16'h0000};
    end else if (i_shift) begin
      r_shreg <= {r_shreg[35:0], 4'h0};
    end
  end

  assign o_nib_cur = r_shreg[39:36];
  assign o_nib_nxt = r_shreg[35:32];

endmodule

// File: rtl/lpc_host.sv
// LPC bus initiator: takes one I/O or memory request at a time and runs the full LPC
// cycle with registered bus outputs, returning read data and a completion status.
module lpc_host
  import lpc_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 32,
  parameter int unsigned ABORT_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cyctype_dir,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_data,
  input  logic [3:0]  lpc_ad_in,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  output logic        lpc_frame,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic [1:0]  resp_status
);

  logic [3:0] r_state;
  logic [3:0] r_cyct;
  logic [7:0] r_cnt;
  logic [5:0] r_sync_cnt;
  logic       r_err;
  logic [7:0] r_rdata;
  logic       r_frame;
  logic [3:0] r_ad;
  logic       r_oe;
  logic       r_resp_valid;
  logic [7:0] r_resp_data;
  logic [1:0] r_resp_status;

  logic [3:0] w_state_next;
  logic [7:0] w_cnt_next;
  logic [5:0] w_sync_cnt_next;
  logic       w_err_next;
  logic [7:0] w_rdata_next;
  logic       w_frame_next;
  logic [3:0] w_ad_next;
  logic       w_oe_next;
  logic       w_resp_valid_next;
  logic [7:0] w_resp_data_next;
  logic [1:0] w_resp_status_next;

  logic       w_accept;
  logic       w_supported;
  logic       w_is_read;
  logic       w_is_mem;
  logic       w_in_shift;
  logic [5:0] w_sync_inc;
  logic [3:0] w_nib_cur;
  logic [3:0] w_nib_nxt;

  assign w_accept    = req_valid && (r_state == ST_IDLE);
  assign w_supported = cyc_supported(req_cyctype_dir[3:2]);
  assign w_is_read   = !r_cyct[DIR_BIT];
  assign w_is_mem    = (r_cyct[3:2] == CYC_MEM);
  assign w_in_shift  = (r_state == ST_ADDR) || (r_state == ST_WDATA);
  assign w_sync_inc  = (r_sync_cnt == 6'h3F) ? r_sync_cnt : r_sync_cnt + 6'd1;

  lpc_nibble_shifter u_shifter (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_accept),
    .i_is_mem  (req_cyctype_dir[3:2] == CYC_MEM),
    .i_addr    (req_addr),
    .i_data    (req_data),
    .i_shift   (w_in_shift),
    .o_nib_cur (w_nib_cur),
    .o_nib_nxt (w_nib_nxt)
  );

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_sync_cnt_next = r_sync_cnt;
    w_err_next      = r_err;
    w_rdata_next    = r_rdata;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_err_next   = 1'b0;
          w_rdata_next = '0;
          if (w_supported) w_state_next = ST_START;
        end
      end
      ST_START: w_state_next = ST_CYCT;
      ST_CYCT: begin
        w_state_next = ST_ADDR;
        w_cnt_next   = w_is_mem ? 8'd7 : 8'd3;
      end
      ST_ADDR: begin
        if (r_cnt == 8'd0) begin
          w_state_next = w_is_read ? ST_HTAR0 : ST_WDATA;
          w_cnt_next   = 8'd1;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      ST_WDATA: begin
        if (r_cnt == 8'd0) w_state_next = ST_HTAR0;
        else               w_cnt_next   = r_cnt - 8'd1;
      end
      ST_HTAR0: w_state_next = ST_HTAR1;
      ST_HTAR1: begin
        w_state_next    = ST_SYNC;
        w_sync_cnt_next = '0;
      end
      ST_SYNC: begin
        case (lpc_ad_in)
          SYNC_READY, SYNC_ERROR: begin
            w_err_next   = (lpc_ad_in == SYNC_ERROR);
            w_state_next = w_is_read ? ST_RDATA : ST_PTAR0;
            w_cnt_next   = 8'd1;
          end
          SYNC_LONG: ;
          default: begin
            // SYNC_SHORT and any unrecognised code both count toward the timeout.
            w_sync_cnt_next = w_sync_inc;
            if ({26'd0, w_sync_inc} >= SYNC_TIMEOUT) begin
              w_state_next = ST_ABORT;
              w_cnt_next   = 8'(ABORT_CYCLES - 1);
            end
          end
        endcase
      end
      ST_RDATA: begin
        if (r_cnt != 8'd0) begin
          w_rdata_next[3:0] = lpc_ad_in;
          w_cnt_next        = 8'd0;
        end else begin
          w_rdata_next[7:4] = lpc_ad_in;
          w_state_next      = ST_PTAR0;
        end
      end
      ST_PTAR0: w_state_next = ST_PTAR1;
      ST_PTAR1: w_state_next = ST_IDLE;
      ST_ABORT: begin
        if (r_cnt == 8'd0) w_state_next = ST_IDLE;
        else               w_cnt_next   = r_cnt - 8'd1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Bus values are derived from the next state so they appear on the bus registered.
  always_comb begin
    w_frame_next = 1'b1;
    w_ad_next    = 4'hF;
    w_oe_next    = 1'b0;
    case (w_state_next)
      ST_START: begin
        w_frame_next = 1'b0;
        w_ad_next    = 4'h0;
        w_oe_next    = 1'b1;
      end
      ST_CYCT: begin
        w_ad_next = r_cyct;
        w_oe_next = 1'b1;
      end
      ST_ADDR, ST_WDATA: begin
        w_ad_next = w_in_shift ? w_nib_nxt : w_nib_cur;
        w_oe_next = 1'b1;
      end
      ST_HTAR0: w_oe_next = 1'b1;
      ST_ABORT: begin
        w_frame_next = 1'b0;
        w_oe_next    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_resp_valid_next  = 1'b0;
    w_resp_data_next   = r_resp_data;
    w_resp_status_next = r_resp_status;
    if (w_accept && !w_supported) begin
      w_resp_valid_next  = 1'b1;
      w_resp_data_next   = '0;
      w_resp_status_next = STAT_UNSUP;
    end else if (r_state == ST_PTAR1) begin
      w_resp_valid_next  = 1'b1;
      w_resp_data_next   = w_is_read ? r_rdata : 8'h00;
      w_resp_status_next = r_err ? STAT_SYNC_ERR : STAT_OK;
    end else if ((r_state == ST_ABORT) && (w_state_next == ST_IDLE)) begin
      w_resp_valid_next  = 1'b1;
      w_resp_data_next   = '0;
      w_resp_status_next = STAT_ABORT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cyct        <= '0;
      r_cnt         <= '0;
      r_sync_cnt    <= '0;
      r_err         <= 1'b0;
      r_rdata       <= '0;
      r_frame       <= 1'b1;
      r_ad          <= 4'hF;
      r_oe          <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_resp_status <= STAT_OK;
    end else begin
      r_state       <= w_state_next;
      if (w_accept) r_cyct <= req_cyctype_dir;
      r_cnt         <= w_cnt_next;
      r_sync_cnt    <= w_sync_cnt_next;
      r_err         <= w_err_next;
      r_rdata       <= w_rdata_next;
      r_frame       <= w_frame_next;
      r_ad          <= w_ad_next;
      r_oe          <= w_oe_next;
      r_resp_valid  <= w_resp_valid_next;
      r_resp_data   <= w_resp_data_next;
      r_resp_status <= w_resp_status_next;
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign lpc_frame   = r_frame;
  assign lpc_ad_out  = r_ad;
  assign lpc_ad_oe   = r_oe;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign resp_status = r_resp_status;

endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: a small LPC responder answers each cycle from a SYNC
// script while the bench records the bus nibble by nibble and checks it.
module tb_lpc_host;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cyctype_dir;
  logic [31:0] req_addr;
  logic [7:0]  req_data;
  logic [3:0]  lpc_ad_in;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic        lpc_frame;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic [1:0]  resp_status;

  int checks = 0;
  int errors = 0;

  logic [3:0] sync_q [16];
  int         sync_len;
  logic [3:0] bus_ad [64];
  logic       bus_oe [64];
  logic       bus_fr [64];
  int         got_len;
  logic [7:0] got_data;
  logic [1:0] got_status;
  logic       got_ready;

  lpc_host #(.SYNC_TIMEOUT(32), .ABORT_CYCLES(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_cyctype_dir (req_cyctype_dir),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .lpc_ad_in       (lpc_ad_in),
    .lpc_ad_out      (lpc_ad_out),
    .lpc_ad_oe       (lpc_ad_oe),
    .lpc_frame       (lpc_frame),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_status     (resp_status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one request (caller sits between a falling and rising edge) and act as the
  // peripheral: after host TAR, play sync_q, then return rdata low nibble first.
  task automatic do_txn(input logic [3:0] cd, input logic [31:0] addr,
                        input logic [7:0] wdata, input logic [7:0] rdata);
    int phase;
    int k;
    logic [3:0] nib;
    logic is_read;
    is_read = !cd[1];
    phase = 0;
    k = 0;
    got_len = -1;
    got_data = 8'hxx;
    got_status = 2'bxx;
    got_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus_ad[i] = 4'hx; bus_oe[i] = 1'bx; bus_fr[i] = 1'bx;
    end
    req_cyctype_dir = cd;
    req_addr = addr;
    req_data = wdata;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 200 && got_len < 0; c++) begin
      @(negedge clock);
      if (c < 64) begin
        bus_ad[c] = lpc_ad_out; bus_oe[c] = lpc_ad_oe; bus_fr[c] = lpc_frame;
      end
      if (resp_valid) begin
        got_len = c; got_data = resp_data; got_status = resp_status; got_ready = req_ready;
      end
      lpc_ad_in = 4'hF;
      if (phase == 0 && lpc_ad_oe) begin
        phase = 1;
      end else if (phase == 1 && !lpc_ad_oe) begin
        phase = 2;
      end else if (phase == 2 || phase == 3) begin
        phase = 3;
        nib = sync_q[(k < sync_len) ? k : sync_len - 1];
        k++;
        lpc_ad_in = nib;
        if (nib == 4'h0 || nib == 4'hA) phase = is_read ? 4 : 6;
      end else if (phase == 4) begin
        lpc_ad_in = rdata[3:0];
        phase = 5;
      end else if (phase == 5) begin
        lpc_ad_in = rdata[7:4];
        phase = 6;
      end
    end
    lpc_ad_in = 4'hF;
    $display("txn cd=%b addr=%h wdata=%h: len=%0d status=%b data=%h",
             cd, addr, wdata, got_len, got_status, got_data);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (lpc_frame !== 1'b1 || lpc_ad_oe !== 1'b0 || lpc_ad_out !== 4'hF) begin
      errors++;
      $display("FAIL reset_bus: frame=%b oe=%b ad=%h required 1 0 f", lpc_frame, lpc_ad_oe, lpc_ad_out);
    end
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 8'h00 || resp_status !== 2'b00) begin
      errors++;
      $display("FAIL reset_resp: ready=%b valid=%b data=%h status=%b required 1 0 00 00",
               req_ready, resp_valid, resp_data, resp_status);
    end
    reset = 1'b0;
    $display("reset: frame=%b oe=%b ad=%h ready=%b", lpc_frame, lpc_ad_oe, lpc_ad_out, req_ready);
  endtask

  task automatic test_io_write();
    logic [3:0] exp_ad [9];
    exp_ad = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h5, 4'hA, 4'hF};
    sync_q[0] = 4'h0; sync_len = 1;
    do_txn(4'b0010, 32'h0000_0080, 8'hA5, 8'h00);
    checks++;
    if (got_len !== 13) begin
      errors++; $display("FAIL io_write_len: got %0d required 13", got_len);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus_ad[i] !== exp_ad[i] || bus_oe[i] !== 1'b1 || bus_fr[i] !== (i != 0)) begin
        errors++;
        $display("FAIL io_write_nib%0d: ad=%h oe=%b fr=%b required %h 1 %b",
                 i, bus_ad[i], bus_oe[i], bus_fr[i], exp_ad[i], (i != 0));
      end
    end
    for (int i = 9; i < 13; i++) begin
      checks++;
      if (bus_oe[i] !== 1'b0 || bus_fr[i] !== 1'b1) begin
        errors++;
        $display("FAIL io_write_tail%0d: oe=%b fr=%b required 0 1", i, bus_oe[i], bus_fr[i]);
      end
    end
    checks++;
    if (got_status !== 2'b00 || got_data !== 8'h00 || got_ready !== 1'b1) begin
      errors++;
      $display("FAIL io_write_resp: status=%b data=%h ready=%b required 00 00 1", got_status, got_data, got_ready);
    end
  endtask

  task automatic test_mem_read_wait();
    sync_q[0] = 4'h5; sync_q[1] = 4'h5; sync_q[2] = 4'h5; sync_q[3] = 4'h0; sync_len = 4;
    do_txn(4'b0100, 32'hFFFF_FFF0, 8'h00, 8'h3C);
    checks++;
    if (got_len !== 20) begin
      errors++; $display("FAIL mem_read_len: got %0d required 20", got_len);
    end
    checks++;
    if (bus_ad[1] !== 4'h4) begin
      errors++; $display("FAIL mem_read_cyct: got %h required 4", bus_ad[1]);
    end
    for (int i = 2; i < 10; i++) begin
      checks++;
      if (bus_ad[i] !== ((i == 9) ? 4'h0 : 4'hF) || bus_oe[i] !== 1'b1) begin
        errors++;
        $display("FAIL mem_read_addr%0d: ad=%h oe=%b required %h 1", i, bus_ad[i], bus_oe[i], (i == 9) ? 4'h0 : 4'hF);
      end
    end
    checks++;
    if (got_data !== 8'h3C || got_status !== 2'b00) begin
      errors++; $display("FAIL mem_read_resp: data=%h status=%b required 3c 00", got_data, got_status);
    end
  endtask

  task automatic test_abort();
    sync_q[0] = 4'h5; sync_len = 1;
    do_txn(4'b0000, 32'h0000_0060, 8'h00, 8'h00);
    checks++;
    if (got_len !== 44) begin
      errors++; $display("FAIL abort_len: got %0d required 44", got_len);
    end
    checks++;
    if (bus_fr[39] !== 1'b1 || bus_oe[39] !== 1'b0) begin
      errors++; $display("FAIL abort_last_sync: fr=%b oe=%b required 1 0", bus_fr[39], bus_oe[39]);
    end
    for (int i = 40; i < 44; i++) begin
      checks++;
      if (bus_fr[i] !== 1'b0 || bus_ad[i] !== 4'hF || bus_oe[i] !== 1'b1) begin
        errors++;
        $display("FAIL abort_bus%0d: fr=%b ad=%h oe=%b required 0 f 1", i, bus_fr[i], bus_ad[i], bus_oe[i]);
      end
    end
    checks++;
    if (got_status !== 2'b10 || got_ready !== 1'b1 || got_data !== 8'h00) begin
      errors++;
      $display("FAIL abort_resp: status=%b ready=%b data=%h required 10 1 00", got_status, got_ready, got_data);
    end
  endtask

  task automatic test_sync_error();
    sync_q[0] = 4'hA; sync_len = 1;
    do_txn(4'b0000, 32'h0000_02F8, 8'h00, 8'h5E);
    checks++;
    if (got_len !== 13) begin
      errors++; $display("FAIL sync_err_len: got %0d required 13", got_len);
    end
    checks++;
    if (got_status !== 2'b01 || got_data !== 8'h5E) begin
      errors++; $display("FAIL sync_err_resp: status=%b data=%h required 01 5e", got_status, got_data);
    end
  endtask

  task automatic test_unsupported();
    sync_q[0] = 4'h0; sync_len = 1;
    do_txn(4'b1000, 32'h0000_1234, 8'h11, 8'h00);
    checks++;
    if (got_len !== 0) begin
      errors++; $display("FAIL unsup_latency: got %0d required 0", got_len);
    end
    checks++;
    if (bus_fr[0] !== 1'b1 || bus_oe[0] !== 1'b0 || got_status !== 2'b11 || got_data !== 8'h00) begin
      errors++;
      $display("FAIL unsup_resp: fr=%b oe=%b status=%b data=%h required 1 0 11 00",
               bus_fr[0], bus_oe[0], got_status, got_data);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    req_cyctype_dir = 4'b0000; req_addr = 32'h0000_0070; req_data = 8'h00;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (lpc_frame !== 1'b1 || lpc_ad_oe !== 1'b1) begin
      errors++; $display("FAIL rst_mid_in_addr: fr=%b oe=%b required 1 1", lpc_frame, lpc_ad_oe);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (lpc_frame !== 1'b1 || lpc_ad_oe !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_immediate: fr=%b oe=%b ready=%b required 1 0 1", lpc_frame, lpc_ad_oe, req_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_resp: resp_valid seen=%b required 0", seen);
    end
    $display("reset mid-cycle: bus released, resp seen=%b", seen);
    sync_q[0] = 4'h0; sync_len = 1;
    do_txn(4'b0000, 32'h0000_0070, 8'h00, 8'h77);
    checks++;
    if (got_len !== 13 || got_status !== 2'b00 || got_data !== 8'h77) begin
      errors++;
      $display("FAIL rst_mid_after: len=%0d status=%b data=%h required 13 00 77", got_len, got_status, got_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ad [10];
    exp_ad = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h3, 4'hC};
    sync_q[0] = 4'h0; sync_len = 1;
    do_txn(4'b0010, 32'h0000_03F8, 8'h12, 8'h00);
    checks++;
    if (got_len !== 13 || got_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first: len=%0d ready=%b required 13 1", got_len, got_ready);
    end
    do_txn(4'b0110, 32'h1234_5678, 8'hC3, 8'h00);
    checks++;
    if (got_len !== 17 || bus_fr[0] !== 1'b0 || bus_ad[1] !== 4'h6) begin
      errors++;
      $display("FAIL b2b_second: len=%0d fr0=%b cyct=%h required 17 0 6", got_len, bus_fr[0], bus_ad[1]);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus_ad[i + 2] !== exp_ad[i]) begin
        errors++; $display("FAIL b2b_nib%0d: got %h required %h", i + 2, bus_ad[i + 2], exp_ad[i]);
      end
    end
    checks++;
    if (got_status !== 2'b00 || got_data !== 8'h00) begin
      errors++; $display("FAIL b2b_resp: status=%b data=%h required 00 00", got_status, got_data);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_cyctype_dir = 4'h0;
    req_addr = '0;
    req_data = '0;
    lpc_ad_in = 4'hF;
    sync_len = 1;
    for (int i = 0; i < 16; i++) sync_q[i] = 4'h0;
    test_reset();
    test_io_write();
    test_mem_read_wait();
    test_abort();
    test_sync_error();
    test_unsupported();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
